mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the memory's general-purpose (data) port between two requesters: the CPU load/store unit (requester 0) and the program loader/debug port (requester 1). The block accepts one access at a time through a req/gnt handshake, drives the memory port from registers, captures read data at a fixed latency and returns it with a valid strobe. It sits between the requesters and `memory`; the instruction-fetch port is not touched.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `LOCK_MAX`, 8, max consecutive grants a locking requester may hold (1..255)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req[1:0]`  in  2  access request per requester; held until granted
- `we[1:0]`  in  2  1 = write, 0 = read; per requester, sampled at grant
- `lock[1:0]`  in  2  keep priority for next access; sampled at grant
- `addr0`, `addr1`  in  AW  access address per requester
- `wdata0`, `wdata1`  in  DW  write data per requester
- `gnt[1:0]`  out  2  one-hot, one-cycle accept pulse (combinational from state/req)
- `rvalid[1:0]`  out  2  one-cycle read-data strobe to owning requester
- `rdata`  out  DW  read data, valid when any `rvalid` bit high
- `mem_addr`  out  AW  to memory general-purpose address
- `mem_we`  out  1  memory write enable, one cycle
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory general-purpose read word, valid 1 cycle after `mem_addr`

## Operation
- States: IDLE, ACCESS, RDWAIT.
- IDLE: if any `req`, select winner, assert its `gnt` this cycle, latch `we`, `addr`, `wdata`, `lock` and owner id; go ACCESS. No req -> stay IDLE.
- Selection: if lock owner is active and `lock_cnt` < LOCK_MAX and owner's `req` high -> owner. Else round-robin: requester other than `last` wins if requesting, else `last`. `last` updated to winner at every grant.
- Lock: granted access with `lock`=1 sets lock owner, increments `lock_cnt`; grant with `lock`=0, or grant to the other requester, clears owner and `lock_cnt`. Reaching LOCK_MAX forces round-robin for the next grant and clears the lock.
- ACCESS: `mem_addr`/`mem_wdata` driven from latches; `mem_we`=1 this cycle only if write. Write -> IDLE. Read -> RDWAIT.
- RDWAIT: register `mem_rdata` into `rdata`, pulse owner's `rvalid` next cycle (coincident with IDLE); go IDLE.
- Requester may drop `req` only after `gnt`; dropping before grant withdraws the request with no side effect.
- Address/data are full AW/DW; no range checking, full 16-bit space valid.

## Timing
- Reset: state IDLE, `gnt`=0, `rvalid`=0, `rdata`=0, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `last`=1 (requester 0 wins first tie), lock cleared, `lock_cnt`=0.
- Read: `gnt` cycle N, `mem_addr` valid N+1, `mem_rdata` sampled end of N+2, `rvalid`/`rdata` in N+3. Next grant earliest N+3 (3-cycle read occupancy).
- Write: `gnt` N, `mem_we`=1 in N+1 only, next grant earliest N+2.
- `rdata` holds last read value until next read; `rvalid` never high with `gnt` for same access.
- Simultaneous `req`=2'b11 in IDLE: exactly one `gnt` bit, per selection rule.
- Reset mid-access: outstanding access abandoned, no `rvalid`, `mem_we` drops immediately.

## Structure
- Shared package `mem_pkg`: state enum (IDLE/ACCESS/RDWAIT), requester id constants (REQ_CPU=0, REQ_LOADER=1), AW/DW defaults.
- One sub-module natural: `rr_lock_sel` (winner selection from `req`, `last`, lock owner, `lock_cnt`); FSM and datapath registers in top.

## Test plan
- Reset then req0 read addr 0x0003 (mem holds 0xBEEF) -> `gnt`=01 cycle N, `mem_addr`=0x0003 N+1, `rvalid`=01 with `rdata`=0xBEEF N+3.
- req1 write 0x0010<=0x1234 -> `mem_we`=1 exactly one cycle with addr 0x0010/data 0x1234; readback by req0 returns 0x1234.
- Both req held continuously, no lock -> grants alternate 01,10,01,10; first after reset is 01.
- req1 with `lock`=1, req0 continuously requesting, LOCK_MAX=3 -> grants 10,10,10,01; lock cleared after third.
- Assert `rst` in RDWAIT -> no `rvalid`, outputs at reset values asynchronously, next read after release completes normally.
- req0 pulses then drops before grant while busy -> no grant issued to req0, no memory access generated.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-port arbiter: FSM states, requester ids,
// default widths and the latched-access record.
package mem_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int CNT_W  = 8;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic we;
    logic id;
  } acc_t;

  function automatic logic [1:0] req_onehot(input logic id);
    return (id == REQ_LOADER) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_lock_sel.sv
// Winner selection: a locking owner keeps the port while under its grant budget,
// otherwise round-robin favouring the requester that did not win last.
module rr_lock_sel
  import mem_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic [1:0]       req_i,
  input  logic             last_i,
  input  logic             lock_vld_i,
  input  logic             lock_id_i,
  input  logic [CNT_W-1:0] lock_cnt_i,
  output logic             win_o
);

  localparam logic [CNT_W-1:0] LMAX = CNT_W'(LOCK_MAX);

  logic other;
  logic hold;

  assign other = ~last_i;
  assign hold  = lock_vld_i && (lock_cnt_i < LMAX) && req_i[lock_id_i];

  // win_o is only consumed when some req bit is set, so falling back to last_i is safe
  always_comb begin
    if (hold)               win_o = lock_id_i;
    else if (req_i[other])  win_o = other;
    else                    win_o = last_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the memory data port: one access in flight, registered
// memory-side outputs, read data returned three cycles after grant.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [1:0]    lock,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LMAX = CNT_W'(LOCK_MAX);

  state_t           state_q;
  acc_t             acc_q;
  logic             last_q;
  logic             lock_vld_q, lock_vld_d;
  logic             lock_id_q,  lock_id_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;
  logic             mem_we_q;
  logic [DW-1:0]    rdata_q;
  logic [1:0]       rvalid_q;

  logic [1:0][AW-1:0] addr_a;
  logic [1:0][DW-1:0] wdata_a;
  logic               win;
  logic               grant_en;

  assign addr_a  = {addr1, addr0};
  assign wdata_a = {wdata1, wdata0};

  rr_lock_sel #(
    .LOCK_MAX (LOCK_MAX)
  ) u_sel (
    .req_i      (req),
    .last_i     (last_q),
    .lock_vld_i (lock_vld_q),
    .lock_id_i  (lock_id_q),
    .lock_cnt_i (lock_cnt_q),
    .win_o      (win)
  );

  assign grant_en = (state_q == IDLE) && (|req);
  assign gnt      = grant_en ? req_onehot(win) : 2'b00;

  // Lock bookkeeping: a run of locked grants is capped at LOCK_MAX, after which the
  // lock is dropped so the next grant goes through round-robin.
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    lock_cnt_d = lock_cnt_q;
    if (grant_en) begin
      if (!lock[win]) begin
        lock_vld_d = 1'b0;
        lock_cnt_d = '0;
      end else begin
        if (lock_vld_q && (lock_id_q == win)) lock_cnt_d = lock_cnt_q + CNT_W'(1);
        else                                  lock_cnt_d = CNT_W'(1);
        lock_id_d  = win;
        lock_vld_d = 1'b1;
        if (lock_cnt_d == LMAX) begin
          lock_vld_d = 1'b0;
          lock_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      last_q      <= REQ_LOADER;
      lock_vld_q  <= 1'b0;
      lock_id_q   <= REQ_CPU;
      lock_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 2'b00;
    end else begin
      mem_we_q   <= 1'b0;
      rvalid_q   <= 2'b00;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      lock_cnt_q <= lock_cnt_d;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            state_q     <= ACCESS;
            last_q      <= win;
            acc_q.we    <= we[win];
            acc_q.id    <= win;
            mem_addr_q  <= addr_a[win];
            mem_wdata_q <= wdata_a[win];
            mem_we_q    <= we[win];
          end
        end
        ACCESS: state_q <= acc_q.we ? IDLE : RDWAIT;
        RDWAIT: begin
          rdata_q  <= mem_rdata;
          rvalid_q <= req_onehot(acc_q.id);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;

endmodule
